// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer: 8259A ICW1..ICW4 init sequencer and OCW1..OCW3 decoder that owns the programmed config registers.
// Optional macro PIC_CASCADE_EN enables ICW3/cascade handling; without it the device is single-mode only.
module pic_init_sequencer #(
    parameter logic [7:0] IMR_INIT = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [1:0] icw_to_be_sent,
    output logic       init_done,
    output logic       ltim,
    output logic       sngl,
    output logic [4:0] vector_base,
    output logic [7:0] icw3_q,
    output logic [7:0] icw4_q,
    output logic [7:0] imr,
    output logic [7:0] ocw2_data,
    output logic       ocw2_stb,
    output logic       poll_stb,
    output logic       read_isr,
    output logic       smm,
    output logic       cmd_err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_ICW2 = 3'd1,
        S_WAIT_ICW3 = 3'd2,
        S_WAIT_ICW4 = 3'd3,
        S_READY     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        wr_n_d_q;
    logic [1:0]  icw_sent_q, icw_sent_d;
    logic        init_done_q, init_done_d;
    logic        ltim_q, ltim_d;
    logic        ic4_q, ic4_d;
    logic [4:0]  vbase_q, vbase_d;
    logic [7:0]  icw4_word_q, icw4_word_d;
    logic [7:0]  imr_q, imr_d;
    logic [7:0]  ocw2_q, ocw2_d;
    logic        ocw2_stb_q, ocw2_stb_d;
    logic        poll_stb_q, poll_stb_d;
    logic        read_isr_q, read_isr_d;
    logic        smm_q, smm_d;
    logic        cmd_err_q, cmd_err_d;
    logic        sngl_eff;
    logic        accept;

`ifdef PIC_CASCADE_EN
    logic        sngl_q, sngl_d;
    logic [7:0]  icw3_word_q, icw3_word_d;
    assign sngl_eff = sngl_q;
`else
    assign sngl_eff = 1'b1;
`endif

    // One accept per falling edge of wr_n; wr_n_d_q tracks wr_n even when deselected.
    assign accept = !cs_n && !wr_n && wr_n_d_q;

    always_comb begin
        state_d     = state_q;
        ltim_d      = ltim_q;
        ic4_d       = ic4_q;
        vbase_d     = vbase_q;
        icw4_word_d = icw4_word_q;
        imr_d       = imr_q;
        ocw2_d      = ocw2_q;
        read_isr_d  = read_isr_q;
        smm_d       = smm_q;
        ocw2_stb_d  = 1'b0;
        poll_stb_d  = 1'b0;
        cmd_err_d   = 1'b0;
`ifdef PIC_CASCADE_EN
        sngl_d      = sngl_q;
        icw3_word_d = icw3_word_q;
`endif
        if (accept) begin
            if (!a0 && din[4]) begin
                ltim_d     = din[3];
                ic4_d      = din[0];
                imr_d      = IMR_INIT;
                read_isr_d = 1'b0;
                smm_d      = 1'b0;
                if (!din[0]) icw4_word_d = 8'h00;
`ifdef PIC_CASCADE_EN
                sngl_d     = din[1];
`endif
                state_d    = S_WAIT_ICW2;
            end else begin
                case (state_q)
                    S_IDLE: cmd_err_d = 1'b1;
                    S_WAIT_ICW2: begin
                        if (a0) begin
                            vbase_d = din[7:3];
                            if (!sngl_eff)  state_d = S_WAIT_ICW3;
                            else if (ic4_q) state_d = S_WAIT_ICW4;
                            else            state_d = S_READY;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
`ifdef PIC_CASCADE_EN
                    S_WAIT_ICW3: begin
                        if (a0) begin
                            icw3_word_d = din;
                            state_d     = ic4_q ? S_WAIT_ICW4 : S_READY;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
`endif
                    S_WAIT_ICW4: begin
                        if (a0) begin
                            icw4_word_d = din;
                            state_d     = S_READY;
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end
                    S_READY: begin
                        if (a0) begin
                            imr_d = din;
                        end else if (!din[3]) begin
                            ocw2_d     = din;
                            ocw2_stb_d = 1'b1;
                        end else if (din[7]) begin
                            cmd_err_d = 1'b1;
                        end else begin
                            poll_stb_d = din[2];
                            if (din[1]) read_isr_d = din[0];
                            if (din[6]) smm_d = din[5];
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Status is decoded from the next state so it registers alongside it.
        case (state_d)
            S_WAIT_ICW2: icw_sent_d = 2'b01;
            S_WAIT_ICW3: icw_sent_d = 2'b10;
            S_WAIT_ICW4: icw_sent_d = 2'b11;
            default:     icw_sent_d = 2'b00;
        endcase
        init_done_d = (state_d == S_READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_n_d_q    <= 1'b1;
            icw_sent_q  <= 2'b00;
            init_done_q <= 1'b0;
            ltim_q      <= 1'b0;
            ic4_q       <= 1'b0;
            vbase_q     <= 5'h00;
            icw4_word_q <= 8'h00;
            imr_q       <= IMR_INIT;
            ocw2_q      <= 8'h00;
            ocw2_stb_q  <= 1'b0;
            poll_stb_q  <= 1'b0;
            read_isr_q  <= 1'b0;
            smm_q       <= 1'b0;
            cmd_err_q   <= 1'b0;
`ifdef PIC_CASCADE_EN
            sngl_q      <= 1'b0;
            icw3_word_q <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            wr_n_d_q    <= wr_n;
            icw_sent_q  <= icw_sent_d;
            init_done_q <= init_done_d;
            ltim_q      <= ltim_d;
            ic4_q       <= ic4_d;
            vbase_q     <= vbase_d;
            icw4_word_q <= icw4_word_d;
            imr_q       <= imr_d;
            ocw2_q      <= ocw2_d;
            ocw2_stb_q  <= ocw2_stb_d;
            poll_stb_q  <= poll_stb_d;
            read_isr_q  <= read_isr_d;
            smm_q       <= smm_d;
            cmd_err_q   <= cmd_err_d;
`ifdef PIC_CASCADE_EN
            sngl_q      <= sngl_d;
            icw3_word_q <= icw3_word_d;
`endif
        end
    end

    assign icw_to_be_sent = icw_sent_q;
    assign init_done      = init_done_q;
    assign ltim           = ltim_q;
    assign vector_base    = vbase_q;
    assign icw4_q         = icw4_word_q;
    assign imr            = imr_q;
    assign ocw2_data      = ocw2_q;
    assign ocw2_stb       = ocw2_stb_q;
    assign poll_stb       = poll_stb_q;
    assign read_isr       = read_isr_q;
    assign smm            = smm_q;
    assign cmd_err        = cmd_err_q;
`ifdef PIC_CASCADE_EN
    assign sngl           = sngl_q;
    assign icw3_q         = icw3_word_q;
`else
    assign sngl           = 1'b1;
    assign icw3_q         = 8'h00;
`endif

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed self-checking bench for pic_init_sequencer (default IMR_INIT = 8'h00).
module tb_pic_init_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] icw_to_be_sent;
    logic       init_done, ltim, sngl, ocw2_stb, poll_stb, read_isr, smm, cmd_err;
    logic [4:0] vector_base;
    logic [7:0] icw3_q, icw4_q, imr, ocw2_data;

    int n_chk = 0;
    int n_fail = 0;

    pic_init_sequencer dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
        .icw_to_be_sent(icw_to_be_sent), .init_done(init_done), .ltim(ltim), .sngl(sngl),
        .vector_base(vector_base), .icw3_q(icw3_q), .icw4_q(icw4_q), .imr(imr),
        .ocw2_data(ocw2_data), .ocw2_stb(ocw2_stb), .poll_stb(poll_stb),
        .read_isr(read_isr), .smm(smm), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Leaves the bench at posedge+1 of the accept edge, i.e. inside cycle N+1.
    task automatic do_write(input logic a, input logic [7:0] d);
        @(posedge clk);
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        @(posedge clk);
        #1;
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (icw_to_be_sent !== 2'b00) begin $display("FAIL reset_icw got=%h exp=0", icw_to_be_sent); n_fail++; end
        n_chk++; if (init_done !== 1'b0) begin $display("FAIL reset_init_done got=%b exp=0", init_done); n_fail++; end
        n_chk++; if (imr !== 8'h00) begin $display("FAIL reset_imr got=%h exp=00", imr); n_fail++; end
        n_chk++; if ({vector_base, icw4_q, ocw2_data} !== 21'h0) begin $display("FAIL reset_regs got=%h exp=0", {vector_base, icw4_q, ocw2_data}); n_fail++; end
        n_chk++; if ({ocw2_stb, poll_stb, cmd_err, read_isr, smm, ltim} !== 6'b0) begin $display("FAIL reset_flags got=%b exp=0", {ocw2_stb, poll_stb, cmd_err, read_isr, smm, ltim}); n_fail++; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle_err();
        do_write(1'b1, 8'h55);
        n_chk++; if (cmd_err !== 1'b1) begin $display("FAIL idle_a0_err got=%b exp=1", cmd_err); n_fail++; end
        n_chk++; if (icw_to_be_sent !== 2'b00) begin $display("FAIL idle_state got=%h exp=0", icw_to_be_sent); n_fail++; end
        next_cycle();
        n_chk++; if (cmd_err !== 1'b0) begin $display("FAIL idle_err_clear got=%b exp=0", cmd_err); n_fail++; end
    endtask

    task automatic test_init_single();
        do_write(1'b0, 8'h13);
        n_chk++; if (icw_to_be_sent !== 2'b01) begin $display("FAIL single_icw1 got=%h exp=1", icw_to_be_sent); n_fail++; end
        n_chk++; if (sngl !== 1'b1) begin $display("FAIL single_sngl got=%b exp=1", sngl); n_fail++; end
        do_write(1'b0, 8'h00);
        n_chk++; if (cmd_err !== 1'b1 || icw_to_be_sent !== 2'b01) begin $display("FAIL wait_err got=%b/%h exp=1/1", cmd_err, icw_to_be_sent); n_fail++; end
        do_write(1'b1, 8'h40);
        n_chk++; if (icw_to_be_sent !== 2'b11) begin $display("FAIL single_icw2 got=%h exp=3", icw_to_be_sent); n_fail++; end
        n_chk++; if (vector_base !== 5'h08) begin $display("FAIL single_vbase got=%h exp=08", vector_base); n_fail++; end
        n_chk++; if (init_done !== 1'b0) begin $display("FAIL single_early_done got=%b exp=0", init_done); n_fail++; end
        do_write(1'b1, 8'h01);
        n_chk++; if (icw_to_be_sent !== 2'b00 || init_done !== 1'b1) begin $display("FAIL single_icw4 got=%h/%b exp=0/1", icw_to_be_sent, init_done); n_fail++; end
        n_chk++; if (icw4_q !== 8'h01) begin $display("FAIL single_icw4_q got=%h exp=01", icw4_q); n_fail++; end
    endtask

    task automatic test_cascade();
        do_write(1'b0, 8'h11);
        do_write(1'b1, 8'h20);
        n_chk++; if (vector_base !== 5'h04) begin $display("FAIL casc_vbase got=%h exp=04", vector_base); n_fail++; end
`ifdef PIC_CASCADE_EN
        n_chk++; if (icw_to_be_sent !== 2'b10) begin $display("FAIL casc_wait3 got=%h exp=2", icw_to_be_sent); n_fail++; end
        do_write(1'b1, 8'h04);
        n_chk++; if (icw_to_be_sent !== 2'b11) begin $display("FAIL casc_wait4 got=%h exp=3", icw_to_be_sent); n_fail++; end
        do_write(1'b1, 8'h03);
        n_chk++; if (icw3_q !== 8'h04 || icw4_q !== 8'h03 || init_done !== 1'b1) begin $display("FAIL casc_done got=%h/%h/%b exp=04/03/1", icw3_q, icw4_q, init_done); n_fail++; end
`else
        n_chk++; if (icw_to_be_sent !== 2'b11) begin $display("FAIL nocasc_skip3 got=%h exp=3", icw_to_be_sent); n_fail++; end
        do_write(1'b1, 8'h04);
        n_chk++; if (icw3_q !== 8'h00 || icw4_q !== 8'h04 || init_done !== 1'b1) begin $display("FAIL nocasc_done got=%h/%h/%b exp=00/04/1", icw3_q, icw4_q, init_done); n_fail++; end
        do_write(1'b1, 8'h03);
        n_chk++; if (imr !== 8'h03) begin $display("FAIL nocasc_ocw1 got=%h exp=03", imr); n_fail++; end
`endif
    endtask

    task automatic test_ocw();
        do_write(1'b1, 8'hA5);
        n_chk++; if (imr !== 8'hA5) begin $display("FAIL ocw1_imr got=%h exp=A5", imr); n_fail++; end
        do_write(1'b0, 8'h20);
        n_chk++; if (ocw2_stb !== 1'b1 || ocw2_data !== 8'h20) begin $display("FAIL ocw2 got=%b/%h exp=1/20", ocw2_stb, ocw2_data); n_fail++; end
        next_cycle();
        n_chk++; if (ocw2_stb !== 1'b0) begin $display("FAIL ocw2_pulse got=%b exp=0", ocw2_stb); n_fail++; end
        do_write(1'b0, 8'h0B);
        n_chk++; if (read_isr !== 1'b1 || poll_stb !== 1'b0) begin $display("FAIL ocw3_ris got=%b/%b exp=1/0", read_isr, poll_stb); n_fail++; end
        do_write(1'b0, 8'h0C);
        n_chk++; if (poll_stb !== 1'b1 || read_isr !== 1'b1) begin $display("FAIL ocw3_poll got=%b/%b exp=1/1", poll_stb, read_isr); n_fail++; end
        next_cycle();
        n_chk++; if (poll_stb !== 1'b0) begin $display("FAIL poll_pulse got=%b exp=0", poll_stb); n_fail++; end
        do_write(1'b0, 8'h68);
        n_chk++; if (smm !== 1'b1) begin $display("FAIL ocw3_smm got=%b exp=1", smm); n_fail++; end
        do_write(1'b0, 8'h88);
        n_chk++; if (cmd_err !== 1'b1) begin $display("FAIL ocw3_bad_err got=%b exp=1", cmd_err); n_fail++; end
        n_chk++; if ({imr, ocw2_data, smm, read_isr, init_done} !== {8'hA5, 8'h20, 3'b111}) begin $display("FAIL ocw3_bad_regs got=%h exp=%h", {imr, ocw2_data, smm, read_isr, init_done}, {8'hA5, 8'h20, 3'b111}); n_fail++; end
        next_cycle();
        n_chk++; if (cmd_err !== 1'b0) begin $display("FAIL err_pulse got=%b exp=0", cmd_err); n_fail++; end
    endtask

    task automatic test_hold_and_cs();
        do_write(1'b1, 8'h3C);
        cs_n = 1'b0; wr_n = 1'b0; din = 8'hC3;
        next_cycle();
        cs_n = 1'b1; wr_n = 1'b1;
        n_chk++; if (imr !== 8'h3C) begin $display("FAIL hold_wr_single got=%h exp=3C", imr); n_fail++; end
        @(negedge clk);
        cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h3C;
        repeat (5) @(posedge clk);
        #1;
        din = 8'h99;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (imr !== 8'h3C) begin $display("FAIL hold_wr_once got=%h exp=3C", imr); n_fail++; end
        wr_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);
        wr_n = 1'b0; din = 8'hFF;
        next_cycle();
        wr_n = 1'b1;
        n_chk++; if (imr !== 8'h3C || cmd_err !== 1'b0) begin $display("FAIL cs_block got=%h/%b exp=3C/0", imr, cmd_err); n_fail++; end
    endtask

    task automatic test_rst_mid();
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'h48);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (icw_to_be_sent !== 2'b00 || init_done !== 1'b0 || imr !== 8'h00 || vector_base !== 5'h00) begin $display("FAIL rst_mid got=%h/%b/%h/%h exp=0/0/00/00", icw_to_be_sent, init_done, imr, vector_base); n_fail++; end
        @(negedge clk);
        rst = 1'b0;
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'h40);
        do_write(1'b1, 8'h01);
        do_write(1'b1, 8'hFF);
        n_chk++; if (imr !== 8'hFF || init_done !== 1'b1) begin $display("FAIL ready_imr_ff got=%h/%b exp=FF/1", imr, init_done); n_fail++; end
        do_write(1'b0, 8'h12);
        n_chk++; if (imr !== 8'h00 || init_done !== 1'b0 || icw_to_be_sent !== 2'b01) begin $display("FAIL icw1_in_ready got=%h/%b/%h exp=00/0/1", imr, init_done, icw_to_be_sent); n_fail++; end
        n_chk++; if (icw4_q !== 8'h00) begin $display("FAIL icw1_clears_icw4 got=%h exp=00", icw4_q); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_idle_err();
        test_init_single();
        test_cascade();
        test_ocw();
        test_hold_and_cs();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
